// File: rtl/boot_loader.sv
`default_nettype none
// boot_loader: receives a length-prefixed program image over valid/ready, writes it into the
// core's program memory and releases the core once loaded. Define BOOT_CSUM_EN for a trailing checksum byte.
module boot_loader #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          cpu_halt,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int            TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DEPTH_W   = DW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_DATA   = 3'd2,
`ifdef BOOT_CSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_SETTLE = 3'd4,
    S_RUN    = 3'd5,
    S_HALTED = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  state_e        state_q;
  logic          in_ready_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q;
  logic          cpu_run_q;
  logic          done_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   len_q;
  logic [TW-1:0] idle_q;
`ifdef BOOT_CSUM_EN
  logic [DW-1:0] csum_q;
`endif

  logic w_accept;
  logic w_timeout;
  logic w_last;

  assign w_accept  = in_valid & in_ready_q;
  // in_ready_q is high exactly in the states where the idle counter runs
  assign w_timeout = (TIMEOUT != 0) && in_ready_q && !w_accept && (idle_q == IDLE_LAST);
  assign w_last    = (({1'b0, addr_q} + {{AW{1'b0}}, 1'b1}) == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_run_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      idle_q     <= '0;
`ifdef BOOT_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      mem_wr_q <= 1'b0;
      if (w_accept) begin
        idle_q <= '0;
      end else if (in_ready_q) begin
        idle_q <= idle_q + TW'(1);
      end

      if (w_timeout) begin
        state_q    <= S_ERROR;
        err_q      <= 1'b1;
        in_ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_HALTED, S_ERROR: begin
            if (start) begin
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              idle_q     <= '0;
              in_ready_q <= 1'b1;
              state_q    <= S_LEN;
`ifdef BOOT_CSUM_EN
              csum_q     <= '0;
`endif
            end
          end
          S_LEN: begin
            if (w_accept) begin
              if (in_data == '0 || in_data > DEPTH_W) begin
                state_q    <= S_ERROR;
                err_q      <= 1'b1;
                in_ready_q <= 1'b0;
              end else begin
                len_q   <= in_data[AW:0];
                addr_q  <= '0;
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_accept) begin
              mem_wr_q   <= 1'b1;
              mem_addr_q <= addr_q;
              mem_data_q <= in_data;
`ifdef BOOT_CSUM_EN
              csum_q     <= csum_q + in_data;
`endif
              if (w_last) begin
`ifdef BOOT_CSUM_EN
                state_q    <= S_CSUM;
`else
                state_q    <= S_SETTLE;
                in_ready_q <= 1'b0;
`endif
              end else begin
                addr_q <= addr_q + AW'(1);
              end
            end
          end
`ifdef BOOT_CSUM_EN
          S_CSUM: begin
            if (w_accept) begin
              in_ready_q <= 1'b0;
              if (in_data == csum_q) begin
                state_q <= S_SETTLE;
              end else begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
              end
            end
          end
`endif
          // Extra cycle lets the final memory write land before the core starts fetching
          S_SETTLE: state_q <= S_RUN;
          S_RUN: begin
            done_q    <= 1'b1;
            cpu_run_q <= !cpu_halt;
            if (cpu_halt) begin
              state_q <= S_HALTED;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            cpu_run_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = in_ready_q;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign cpu_run  = cpu_run_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// Directed bench for boot_loader: expected memory writes are queued from the stimulus and
// checked every cycle, alongside hand-computed expectations for handshake, timing and errors.
module tb_boot_loader;
  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'hEE;
  logic       cpu_halt = 1'b0;
  logic       in_ready, mem_wr, cpu_run, busy, done, err;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;

  int          checks   = 0;
  int          failures = 0;
  int          nwr      = 0;
  logic [12:0] exp_q[$];
  logic [4:0]  m_addr   = '0;
  logic [7:0]  m_data   = '0;
  logic [7:0]  img[$];

  boot_loader #(.DEPTH(32), .AW(5), .DW(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cpu_halt(cpu_halt), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted data byte must appear as exactly one write pulse on the following cycle;
  // between pulses the write address/data must hold the last written values.
  initial begin : compare
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("wr_pulse", mem_wr, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (mem_wr) begin
            nwr++;
            m_addr = e[12:8];
            m_data = e[7:0];
          end
        end
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_data);
        chk("busy_eq_ready", busy, in_ready);
        chk("run_implies_done", cpu_run && !done, 0);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    chk("ready_for_byte", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 8'hEE;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic halt_core();
    @(negedge clk);
    cpu_halt = 1'b1;
    chk("run_before_halt", cpu_run, 1);
    @(negedge clk);
    chk("run_after_halt", cpu_run, 0);
    chk("done_after_halt", done, 1);
    cpu_halt = 1'b0;
  endtask

  task automatic load(input int gap, input int stall_at, input int stall_len,
                      input logic [7:0] csum_delta, input bit expect_ok);
    logic [7:0] sum = 8'h00;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("err_cleared", err, 0);
    nwr = 0;
    send(8'(img.size()));
    for (int i = 0; i < img.size(); i++) begin
      if (i == stall_at) repeat (stall_len) @(negedge clk);
      repeat (gap) @(negedge clk);
      send(img[i]);
      exp_q.push_back({5'(i), img[i]});
      sum = sum + img[i];
    end
`ifdef BOOT_CSUM_EN
    send(sum + csum_delta);
`endif
    if (expect_ok) begin
      @(negedge clk);
      @(negedge clk);
      chk("run_low_1_after_last", cpu_run, 0);
      chk("done_low_1_after_last", done, 0);
      @(negedge clk);
      chk("run_2_after_last", cpu_run, 1);
      chk("done_2_after_last", done, 1);
      chk("err_ok_load", err, 0);
      chk("ready_in_run", in_ready, 0);
    end else begin
      @(negedge clk);
      chk("err_bad_load", err, 1);
      chk("run_bad_load", cpu_run, 0);
      chk("ready_bad_load", in_ready, 0);
      chk("done_bad_load", done, 0);
    end
    chk("write_count", nwr, img.size());
  endtask

  initial begin : main
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 0);

    // Basic three-byte image
    img.delete();
    img.push_back(8'hA1); img.push_back(8'hB2); img.push_back(8'hC3);
    load(0, -1, 0, 8'h00, 1'b1);
    chk("img1_last_addr", mem_addr, 5'd2);
    chk("img1_last_data", mem_data, 8'hC3);

    // start has no effect while the core runs
    pulse_start();
    @(negedge clk);
    chk("start_ign_busy", busy, 0);
    chk("start_ign_run", cpu_run, 1);
    halt_core();

    // Illegal lengths: zero and DEPTH+1
    pulse_start();
    send(8'h00);
    @(negedge clk);
    chk("len0_err", err, 1);
    chk("len0_ready", in_ready, 0);
    chk("len0_done", done, 0);
    pulse_start();
    chk("len33_err_cleared", err, 0);
    send(8'h21);
    @(negedge clk);
    chk("len33_err", err, 1);
    chk("len33_busy", busy, 0);

    // Full-depth image with in_valid toggling every cycle
    img.delete();
    for (int i = 0; i < 32; i++) img.push_back(8'(i * 37 + 5));
    load(1, -1, 0, 8'h00, 1'b1);
    chk("full_last_addr", mem_addr, 5'd31);
    chk("full_last_data", mem_data, 8'h80);
    halt_core();

    // Eight idle cycles after the second data byte trips the timeout
    pulse_start();
    send(8'h04);
    send(8'h11); exp_q.push_back({5'd0, 8'h11});
    send(8'h22); exp_q.push_back({5'd1, 8'h22});
    repeat (8) @(negedge clk);
    chk("to_not_yet", err, 0);
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_ready", in_ready, 0);
    chk("to_run", cpu_run, 0);

    // Seven idle cycles is tolerated
    img.delete();
    img.push_back(8'h11); img.push_back(8'h22); img.push_back(8'h33); img.push_back(8'h44);
    load(0, 2, 7, 8'h00, 1'b1);
    halt_core();

`ifdef BOOT_CSUM_EN
    img.delete();
    img.push_back(8'h10); img.push_back(8'h20);
    load(0, -1, 0, 8'h01, 1'b0);
    load(0, -1, 0, 8'h00, 1'b1);
    halt_core();
`endif

    // Reset in the middle of a load
    pulse_start();
    send(8'h05);
    send(8'h01); exp_q.push_back({5'd0, 8'h01});
    send(8'h02); exp_q.push_back({5'd1, 8'h02});
    @(negedge clk);
    chk("midload_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_mem_wr", mem_wr, 0);
    chk("mrst_mem_addr", mem_addr, 0);
    chk("mrst_mem_data", mem_data, 0);
    chk("mrst_cpu_run", cpu_run, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    exp_q.delete();
    m_addr = '0;
    m_data = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_run", cpu_run, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit reached");
  end

endmodule
`default_nettype wire
